ray_marcher: RTL and testbench
==============================

Name: ray_marcher

Overview:
Parametrised fixed-point ray marcher for the raycast renderer: one ray per start/done transaction.
- Each ray is given by player position and a precomputed direction vector (sin/cos supplied externally).
- Steps along the ray, probes an external map RAM, and stops on a wall, map edge or distance cap.
- Computes the wall's top screen row with an on-block iterative divider.
- Sits between the column sequencer (upstream) and the column renderer (downstream).

Parameters:
FRAC_BITS, 5, fractional bits of all position/direction values
POS_W, 32, width of player_x/player_y
DIR_W, 16, width of signed dir_x/dir_y
DIST_W, 13, width of distance accumulator
MAP_W, 8, map width in cells (power of 2)
MAP_H, 8, map height in cells (power of 2)
STEP, 8, distance increment per probe (fixed-point)
MAX_DIST, 512, distance reported on edge/cap
HORIZON, 7680, screen horizon value
HEIGHT_K, 245760, projection constant (dividend)
Q_W, 20, quotient/top width; divider runs Q_W cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  launch ray (sampled only in IDLE)
player_x  in  POS_W  unsigned fixed-point x
player_y  in  POS_W  unsigned fixed-point y
dir_x  in  DIR_W  signed fixed-point ray x component
dir_y  in  DIR_W  signed fixed-point ray y component
busy  out  1  high in every state but IDLE
map_rd  out  1  map read strobe
map_addr  out  clog2(MAP_W*MAP_H)  cell_y*MAP_W + cell_x
map_wall  in  1  map data, valid the cycle after map_rd
done  out  1  one-cycle pulse, results valid
dist  out  DIST_W  hit distance
top  out  Q_W  wall top row
hit_edge  out  1  ray left the map or hit the cap
hit_side  out  1  wall face orientation (optional feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, map_rd, dist, top, hit_edge and hit_side all 0; internal registers cleared. Applies mid-ray too: the ray is abandoned, no done.
- IDLE: start=1 latches all inputs, sets d=0, goes to MULT. start while busy is ignored.
- MULT (1 cycle):
  - pos_x = player_x + ((dir_x*d) >>> FRAC_BITS), signed full-width product.
  - pos_y computed the same way with player_y, dir_y.
  - cell = pos >>> FRAC_BITS (signed).
- ADDR (1 cycle):
  - If cell_x<0, cell_x>=MAP_W, cell_y<0 or cell_y>=MAP_H: hit_edge=1, d=MAX_DIST, go to DIV with no read.
  - Otherwise map_rd=1 and map_addr is driven; go to CHECK.
- CHECK (1 cycle):
  - map_wall=1: hit_edge=0, go to DIV.
  - Else if d+STEP>=MAX_DIST: d=MAX_DIST, hit_edge=1, go to DIV.
  - Else d+=STEP, back to MULT.
- DIV (Q_W cycles): restoring radix-2 divide, q = HEIGHT_K / d.
  - top = HORIZON - q, clamped to 0 if q>HORIZON.
  - d=0 (wall in the player's own cell): no divide, top=0, still Q_W cycles.
- DONE (1 cycle): dist, top, hit_edge, hit_side update; done=1; then IDLE.
- Outputs hold their values until the next DONE.
- Latency: with start accepted at cycle 0 and N probes reaching CHECK, done=1 at cycle 3N+Q_W+1. An edge exit at probe N costs 2 cycles in place of that probe's 3.
- map_rd is high only in ADDR; map_addr is don't-care elsewhere.

Optional Feature:
- Macro RAYCAST_SIDE_EN defined: cell_x and cell_y from the previous probe are kept.
  - On a wall hit, hit_side=1 if cell_x changed on the final step and cell_y did not; otherwise 0.
  - Edge/cap terminations give hit_side=0.
- Not defined: hit_side is tied 0 and the previous-cell registers are not built.

Test Plan:
- Wall hit: player (112,112), dir (32,0), map cell (5,3) wall, rest empty -> 7 probes, dist=48, top=7680-5120=2560, hit_edge=0, done at cycle 42 (Q_W=20), hit_side=1 with RAYCAST_SIDE_EN.
- Edge exit: same player/dir, empty map -> cell_x reaches 8 at d=144, dist=512, top=7680-480=7200, hit_edge=1, no map_rd on the final probe.
- Own-cell wall: player (112,112) inside a wall cell -> dist=0, top=0, done at cycle 3+20+1=24.
- Negative direction: player (16,112), dir (-32,0), empty map -> cell_x=-1 at d=24, dist=512, hit_edge=1.
- Start ignored while busy, and reset mid-DIV: start pulses during a ray change nothing; rst_n=0 during DIV -> busy=0 and all outputs 0 immediately, no done.
- Back-to-back: start held high -> second ray launches the cycle after DONE, its results are independent, done pulses twice.

Source files
------------

// File: rtl/ray_marcher.sv
// ray_marcher: fixed-point ray marcher, one ray per start/done transaction.
//
// Walks a ray from the player position in fixed steps of STEP. At each probe
// it forms pos = player + (dir * d) >>> FRAC_BITS, converts the position to a
// map cell and reads that cell from an external map RAM. The march stops on a
// wall, when the ray leaves the map, or when the distance reaches MAX_DIST. A
// restoring radix-2 divider then forms q = HEIGHT_K / d, and the wall top row
// is HORIZON - q, clamped to 0.
//
// Optional feature: define RAYCAST_SIDE_EN to report the wall face
// orientation on hit_side_o. With the macro undefined, hit_side_o is tied 0.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset; abandons a ray in flight
//   start_i       launch a ray (sampled only while idle)
//   player_x_i/y  unsigned fixed-point player position
//   dir_x_i/y     signed fixed-point ray direction
//   busy_o        high whenever a ray is in flight
//   map_rd_o      map read strobe; map_wall_i is valid the following cycle
//   map_addr_o    cell_y * MAP_W + cell_x
//   map_wall_i    map data for the previous read
//   done_o        one-cycle pulse; dist_o/top_o/hit_edge_o/hit_side_o valid
//   dist_o        hit distance (MAX_DIST on edge or cap)
//   top_o         wall top screen row
//   hit_edge_o    ray left the map or reached the distance cap
//   hit_side_o    wall face crossed in x only (RAYCAST_SIDE_EN builds)
module ray_marcher #(
  parameter int unsigned FRAC_BITS = 5,
  parameter int unsigned POS_W     = 32,
  parameter int unsigned DIR_W     = 16,
  parameter int unsigned DIST_W    = 13,
  parameter int unsigned MAP_W     = 8,
  parameter int unsigned MAP_H     = 8,
  parameter int unsigned STEP      = 8,
  parameter int unsigned MAX_DIST  = 512,
  parameter int unsigned HORIZON   = 7680,
  parameter int unsigned HEIGHT_K  = 245760,
  parameter int unsigned Q_W       = 20
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              start_i,
  input  logic [POS_W-1:0]                  player_x_i,
  input  logic [POS_W-1:0]                  player_y_i,
  input  logic signed [DIR_W-1:0]           dir_x_i,
  input  logic signed [DIR_W-1:0]           dir_y_i,
  output logic                              busy_o,
  output logic                              map_rd_o,
  output logic [$clog2(MAP_W*MAP_H)-1:0]    map_addr_o,
  input  logic                              map_wall_i,
  output logic                              done_o,
  output logic [DIST_W-1:0]                 dist_o,
  output logic [Q_W-1:0]                    top_o,
  output logic                              hit_edge_o,
  output logic                              hit_side_o
);

  // Positions carry one extra bit so a step behind the player can go negative.
  localparam int unsigned PW     = POS_W + 1;
  localparam int unsigned PROD_W = DIR_W + DIST_W + 1;
  localparam int unsigned XB     = $clog2(MAP_W);
  localparam int unsigned YB     = $clog2(MAP_H);
  localparam int unsigned CNT_W  = $clog2(Q_W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StMult,
    StAddr,
    StCheck,
    StDiv,
    StDone
  } state_e;

  state_e                   state_q;
  logic [POS_W-1:0]         px_q, py_q;
  logic signed [DIR_W-1:0]  dx_q, dy_q;
  logic [DIST_W-1:0]        d_q;
  logic signed [PW-1:0]     cell_x_q, cell_y_q;
  logic                     edge_q;
  logic [DIST_W-1:0]        rem_q;
  logic [Q_W-1:0]           quo_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     done_q;
  logic [DIST_W-1:0]        dist_q;
  logic [Q_W-1:0]           top_q;
  logic                     hit_edge_q;

`ifdef RAYCAST_SIDE_EN
  logic signed [PW-1:0]     prev_x_q, prev_y_q;
  logic                     side_q;
  logic                     hit_side_q;
`endif

  // Probe position for the current distance.
  logic signed [PROD_W-1:0] dx_ext, dy_ext, d_ext, prod_x, prod_y;
  logic signed [PW-1:0]     pos_x, pos_y, cell_x_n, cell_y_n;

  always_comb begin
    dx_ext   = PROD_W'(dx_q);
    dy_ext   = PROD_W'(dy_q);
    d_ext    = PROD_W'({1'b0, d_q});
    prod_x   = dx_ext * d_ext;
    prod_y   = dy_ext * d_ext;
    pos_x    = $signed({1'b0, px_q}) + PW'(prod_x >>> FRAC_BITS);
    pos_y    = $signed({1'b0, py_q}) + PW'(prod_y >>> FRAC_BITS);
    cell_x_n = pos_x >>> FRAC_BITS;
    cell_y_n = pos_y >>> FRAC_BITS;
  end

  // Map dimensions are powers of two: a cell is inside iff it is non-negative
  // and has no bits set above the index field.
  logic out_of_map;

  always_comb begin
    out_of_map = cell_x_q[PW-1] | (|cell_x_q[PW-2:XB]) |
                 cell_y_q[PW-1] | (|cell_y_q[PW-2:YB]);
  end

  logic [DIST_W:0] d_plus;
  logic            cap_hit;

  always_comb begin
    d_plus  = {1'b0, d_q} + (DIST_W+1)'(STEP);
    cap_hit = d_plus >= (DIST_W+1)'(MAX_DIST);
  end

  // One restoring-division step: the dividend shifts out of quo_q's MSB into
  // the partial remainder while quotient bits shift in at the LSB.
  logic [DIST_W:0]   trial;
  logic              div_ge;
  logic [DIST_W-1:0] rem_step;
  logic [Q_W-1:0]    quo_step;
  logic [Q_W-1:0]    top_n;

  always_comb begin
    trial    = {rem_q, quo_q[Q_W-1]};
    div_ge   = trial >= {1'b0, d_q};
    rem_step = div_ge ? DIST_W'(trial - {1'b0, d_q}) : DIST_W'(trial);
    quo_step = {quo_q[Q_W-2:0], div_ge};
    // d = 0 means the player stands inside a wall; the quotient is meaningless.
    if ((d_q == '0) || (quo_step > Q_W'(HORIZON))) begin
      top_n = '0;
    end else begin
      top_n = Q_W'(HORIZON) - quo_step;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      px_q       <= '0;
      py_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      d_q        <= '0;
      cell_x_q   <= '0;
      cell_y_q   <= '0;
      edge_q     <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      dist_q     <= '0;
      top_q      <= '0;
      hit_edge_q <= 1'b0;
`ifdef RAYCAST_SIDE_EN
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      side_q     <= 1'b0;
      hit_side_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            px_q    <= player_x_i;
            py_q    <= player_y_i;
            dx_q    <= dir_x_i;
            dy_q    <= dir_y_i;
            d_q     <= '0;
            state_q <= StMult;
          end
        end

        StMult: begin
          cell_x_q <= cell_x_n;
          cell_y_q <= cell_y_n;
`ifdef RAYCAST_SIDE_EN
          // The first probe has no predecessor; treat it as unchanged.
          prev_x_q <= (d_q == '0) ? cell_x_n : cell_x_q;
          prev_y_q <= (d_q == '0) ? cell_y_n : cell_y_q;
`endif
          state_q  <= StAddr;
        end

        StAddr: begin
          if (out_of_map) begin
            edge_q  <= 1'b1;
            d_q     <= DIST_W'(MAX_DIST);
            rem_q   <= '0;
            quo_q   <= Q_W'(HEIGHT_K);
            cnt_q   <= '0;
`ifdef RAYCAST_SIDE_EN
            side_q  <= 1'b0;
`endif
            state_q <= StDiv;
          end else begin
            state_q <= StCheck;
          end
        end

        StCheck: begin
          if (map_wall_i) begin
            edge_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= Q_W'(HEIGHT_K);
            cnt_q   <= '0;
`ifdef RAYCAST_SIDE_EN
            side_q  <= (cell_x_q != prev_x_q) && (cell_y_q == prev_y_q);
`endif
            state_q <= StDiv;
          end else if (cap_hit) begin
            edge_q  <= 1'b1;
            d_q     <= DIST_W'(MAX_DIST);
            rem_q   <= '0;
            quo_q   <= Q_W'(HEIGHT_K);
            cnt_q   <= '0;
`ifdef RAYCAST_SIDE_EN
            side_q  <= 1'b0;
`endif
            state_q <= StDiv;
          end else begin
            d_q     <= d_plus[DIST_W-1:0];
            state_q <= StMult;
          end
        end

        StDiv: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt_q <= cnt_q + 1'b1;
          // Results are published on entry to DONE so they are visible with done.
          if (cnt_q == CNT_W'(Q_W - 1)) begin
            dist_q     <= d_q;
            top_q      <= top_n;
            hit_edge_q <= edge_q;
`ifdef RAYCAST_SIDE_EN
            hit_side_q <= side_q;
`endif
            done_q     <= 1'b1;
            state_q    <= StDone;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy_o     = (state_q != StIdle);
    map_rd_o   = (state_q == StAddr) && !out_of_map;
    map_addr_o = {cell_y_q[YB-1:0], cell_x_q[XB-1:0]};
    done_o     = done_q;
    dist_o     = dist_q;
    top_o      = top_q;
    hit_edge_o = hit_edge_q;
`ifdef RAYCAST_SIDE_EN
    hit_side_o = hit_side_q;
`else
    hit_side_o = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ray_marcher.sv
// Bench for ray_marcher: directed rays against a behavioural march model that
// predicts, per cycle, busy, map reads, done timing and the held results.
module tb_ray_marcher;

  localparam int FRAC  = 5;
  localparam int MW    = 8;
  localparam int MH    = 8;
  localparam int STEP  = 8;
  localparam int MAXD  = 512;
  localparam int HOR   = 7680;
  localparam int HK    = 245760;
  localparam int QW    = 20;
`ifdef RAYCAST_SIDE_EN
  localparam int SIDE_EN = 1;
`else
  localparam int SIDE_EN = 0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               start_i;
  logic [31:0]        player_x_i, player_y_i;
  logic signed [15:0] dir_x_i, dir_y_i;
  logic               busy_o, map_rd_o, done_o, hit_edge_o, hit_side_o;
  logic [5:0]         map_addr_o;
  logic               map_wall_i = 1'b0;
  logic [12:0]        dist_o;
  logic [19:0]        top_o;

  always #5 clk_i = ~clk_i;

  ray_marcher dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .player_x_i (player_x_i),
    .player_y_i (player_y_i),
    .dir_x_i    (dir_x_i),
    .dir_y_i    (dir_y_i),
    .busy_o     (busy_o),
    .map_rd_o   (map_rd_o),
    .map_addr_o (map_addr_o),
    .map_wall_i (map_wall_i),
    .done_o     (done_o),
    .dist_o     (dist_o),
    .top_o      (top_o),
    .hit_edge_o (hit_edge_o),
    .hit_side_o (hit_side_o)
  );

  // Map RAM: one-cycle read latency.
  bit map_mem [64];
  always @(posedge clk_i) if (map_rd_o) map_wall_i <= map_mem[map_addr_o];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Hand-computed results per accepted ray (-1 latency: no literal).
  localparam int NLIT = 9;
  int lit_L    [NLIT] = '{42, 77, 24, 32, 213, 66, -1, 42, 32};
  int lit_dist [NLIT] = '{48, 512, 0, 512, 512, 112, 0, 48, 512};
  int lit_top  [NLIT] = '{2560, 7200, 0, 7200, 7200, 5486, 0, 2560, 7200};
  int lit_edge [NLIT] = '{0, 1, 0, 1, 1, 0, 0, 0, 1};
  int lit_side [NLIT] = '{SIDE_EN, 0, 0, 0, 0, 0, 0, SIDE_EN, 0};

  // Model results for the ray in flight.
  bit     rd_s [256];
  int     ad_s [256];
  int     m_L, m_dist, m_top, m_edge, m_side;

  task automatic model_ray(input longint px, input longint py,
                           input longint dx, input longint dy);
    longint d, posx, posy, cx, cy, pcx, pcy;
    int     p;
    bit     fin;
    for (int i = 0; i < 256; i++) begin
      rd_s[i] = 1'b0;
      ad_s[i] = 0;
    end
    d = 0; p = 0; fin = 1'b0; pcx = 0; pcy = 0;
    while (!fin) begin
      posx = px + ((dx * d) >>> FRAC);
      posy = py + ((dy * d) >>> FRAC);
      cx   = posx >>> FRAC;
      cy   = posy >>> FRAC;
      if (p == 0) begin
        pcx = cx;
        pcy = cy;
      end
      // Each probe costs MULT, ADDR, CHECK; an edge exit skips CHECK.
      if (cx < 0 || cx >= MW || cy < 0 || cy >= MH) begin
        m_edge = 1; m_dist = MAXD; m_side = 0;
        m_L = 3 * p + 2 + QW + 1;
        fin = 1'b1;
      end else begin
        rd_s[3*p+2] = 1'b1;
        ad_s[3*p+2] = int'(cy * MW + cx);
        if (map_mem[int'(cy * MW + cx)]) begin
          m_edge = 0; m_dist = int'(d);
          m_side = (SIDE_EN != 0 && cx != pcx && cy == pcy) ? 1 : 0;
          m_L = 3 * (p + 1) + QW + 1;
          fin = 1'b1;
        end else if (d + STEP >= MAXD) begin
          m_edge = 1; m_dist = MAXD; m_side = 0;
          m_L = 3 * (p + 1) + QW + 1;
          fin = 1'b1;
        end else begin
          d = d + STEP;
          p++;
          pcx = cx;
          pcy = cy;
        end
      end
    end
    if (m_dist == 0) m_top = 0;
    else if (HK / m_dist > HOR) m_top = 0;
    else m_top = HOR - HK / m_dist;
  endtask

  // Compare process state.
  bit act = 1'b0;
  int k = 0;
  int cur_id = 0;
  int ray_cnt = 0;
  int h_dist = 0, h_top = 0, h_edge = 0, h_side = 0;
  bit e_busy, e_rd, e_done;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        act = 1'b0; k = 0;
        h_dist = 0; h_top = 0; h_edge = 0; h_side = 0;
        e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
      end else if (act) begin
        e_busy = 1'b1;
        e_rd   = rd_s[k];
        e_done = (k == m_L);
        if (e_done) begin
          h_dist = m_dist; h_top = m_top; h_edge = m_edge; h_side = m_side;
        end
      end else begin
        e_busy = 1'b0; e_rd = 1'b0; e_done = 1'b0;
      end
      chk("busy", busy_o, e_busy);
      chk("map_rd", map_rd_o, e_rd);
      chk("done", done_o, e_done);
      if (e_rd) chk("map_addr", map_addr_o, ad_s[k]);
      chk("dist", dist_o, h_dist);
      chk("top", top_o, h_top);
      chk("hit_edge", hit_edge_o, h_edge);
      chk("hit_side", hit_side_o, h_side);
      if (rst_ni) begin
        if (act) begin
          if (k == m_L) act = 1'b0;
          else k++;
        end else if (start_i) begin
          model_ray(longint'(player_x_i), longint'(player_y_i),
                    longint'(dir_x_i), longint'(dir_y_i));
          cur_id = ray_cnt;
          ray_cnt++;
          if (cur_id < NLIT && lit_L[cur_id] >= 0) begin
            chk("lit_latency", m_L, lit_L[cur_id]);
            chk("lit_dist", m_dist, lit_dist[cur_id]);
            chk("lit_top", m_top, lit_top[cur_id]);
            chk("lit_edge", m_edge, lit_edge[cur_id]);
            chk("lit_side", m_side, lit_side[cur_id]);
          end
          act = 1'b1;
          k = 1;
        end
      end
    end
  end

  task automatic clear_map();
    for (int i = 0; i < 64; i++) map_mem[i] = 1'b0;
  endtask

  task automatic set_ray(input int px, input int py, input int dx, input int dy);
    player_x_i = 32'(px);
    player_y_i = 32'(py);
    dir_x_i    = 16'(dx);
    dir_y_i    = 16'(dy);
  endtask

  task automatic start_ray(input int px, input int py, input int dx, input int dy);
    @(posedge clk_i); #1;
    set_ray(px, py, dx, dy);
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && act; i++) @(posedge clk_i);
    #1;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    set_ray(0, 0, 0, 0);
    clear_map();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // 0: wall at (5,3)
    map_mem[29] = 1'b1;
    start_ray(112, 112, 32, 0); wait_idle();
    // 1: empty map, exits at x edge
    clear_map();
    start_ray(112, 112, 32, 0); wait_idle();
    // 2: wall in the player's own cell
    map_mem[27] = 1'b1;
    start_ray(112, 112, 32, 0); wait_idle();
    // 3: negative direction leaves through x = -1
    clear_map();
    start_ray(16, 112, -32, 0); wait_idle();
    // 4: zero direction runs to the distance cap
    start_ray(112, 112, 0, 0); wait_idle();
    // 5: y-face wall at (3,4), with start pulses that must be ignored
    map_mem[35] = 1'b1;
    start_ray(112, 16, 0, 32);
    repeat (8) @(posedge clk_i);
    #1 set_ray(16, 16, 32, 32); start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    for (int i = 0; i < 200 && act && k < 50; i++) @(posedge clk_i);
    #1 start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
    set_ray(0, 0, 0, 0);
    wait_idle();
    // 6: reset in the middle of the divide
    clear_map();
    map_mem[29] = 1'b1;
    start_ray(112, 112, 32, 0);
    for (int i = 0; i < 200 && act && k < 30; i++) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    // 7, 8: start held high, inputs change while the first ray runs
    #1 set_ray(112, 112, 32, 0); start_i = 1'b1;
    for (int i = 0; i < 200 && ray_cnt < 8; i++) @(posedge clk_i);
    #1 set_ray(16, 112, -32, 0);
    for (int i = 0; i < 200 && ray_cnt < 9; i++) @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
